stream_upsizer: RTL and testbench
=================================

Name: stream_upsizer

Overview:
- Packs a narrow stream (MstStreamWidth, default 64 b) into full-width beats (SlvStreamWidth, default 256 b) for the wide stream_downsizer input port.
- Packing order is the inverse of the downsizer's split order, so upsizer → downsizer is an identity path: the first narrow word received occupies the most significant slice.
- Supports an explicit flush, which emits a partial beat.
- Optionally throttles intake on the downstream half-full indication.

Parameters:
- SlvStreamWidth, 256, width of the packed output beat in bits.
- MstStreamWidth, 64, width of the narrow input word in bits. SlvStreamWidth must be an exact multiple of it.
- UseHfBackpressure, 1, when 1 the intake is also gated by m_axis_hf_resp.tready.
- s_axis_req_t / s_axis_resp_t, logic, narrow-side stream structs (tvalid, t.data / tready).
- m_axis_req_t / m_axis_resp_t, logic, wide-side stream structs.
- s_axis_data_t, logic, narrow payload type (MstStreamWidth bits).

Ports:
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_axis_req  in  s_axis_req_t  narrow input: tvalid, t.data.
- s_axis_resp  out  s_axis_resp_t  narrow input tready.
- m_axis_req  out  m_axis_req_t  wide output: tvalid, t.data.
- m_axis_resp  in  m_axis_resp_t  wide output tready.
- m_axis_hf_resp  in  m_axis_resp_t  downstream half-full ready; tready=1 means room for at least threshold beats.
- flush_i  in  1  single-cycle request to emit the pending partial beat.
- m_lane_cnt  out  SelWidth+1  number of valid narrow lanes in the current output beat, 1..LaneNum. Valid with m_axis_req.tvalid.

Behaviour:
- LaneNum = SlvStreamWidth/MstStreamWidth. SelWidth = idx_width(LaneNum).
- State:
  - accumulator acc[LaneNum-1:0] of narrow words.
  - lane counter cnt, range 0..LaneNum-1.
  - output register obuf with ovalid and olanes.
  - flush_pend flag.
- Reset (async assert; deassertion is synchronised externally): cnt=0, flush_pend=0, ovalid=0, acc=0, obuf=0, m_lane_cnt=0. All outputs low/zero.
- Output handshake:
  - m_axis_req.tvalid = ovalid.
  - Once asserted, tvalid and data stay stable until m_axis_resp.tready. No retraction.
- obuf_free = !ovalid || m_axis_resp.tready. This is the same-cycle drain, giving full throughput.
- Intake ready, s_axis_resp.tready =
  - !flush_pend,
  - && (cnt != LaneNum-1 || obuf_free),
  - && (!UseHfBackpressure || m_axis_hf_resp.tready).
  - This is combinational with no dependency on s_axis_req.tvalid.
- Narrow-word accept (tvalid && tready):
  - the word is written to lane slice (LaneNum-1-cnt), i.e. first word → MSB slice.
  - If cnt==LaneNum-1: obuf ← acc with the new word merged in, olanes=LaneNum, ovalid=1, cnt←0, acc←0.
  - Otherwise cnt←cnt+1.
- Latency: the last narrow word is accepted in cycle N; the wide beat is valid in cycle N+1.
- Throughput: one narrow word per cycle, sustained. A wide beat is emitted every LaneNum cycles with no bubble.
- Flush:
  - flush_i with cnt==0, no accept this cycle and flush_pend=0: ignored.
  - flush_i with an accept in the same cycle: the word is included first. If that word completes the beat, the flush is a no-op. Otherwise a partial beat is emitted containing the new word.
  - Partial emit: requires obuf_free. obuf ← acc with unused low lanes zero, olanes=lane count, cnt←0, acc←0.
  - If !obuf_free: set flush_pend and hold intake off. The partial beat is emitted on the first obuf_free cycle, then flush_pend clears.
  - flush_i while flush_pend=1: absorbed; no second beat.
- Wrap: cnt wraps LaneNum-1 → 0 only via the full-beat or flush paths. Never increments past LaneNum-1.
- Reset mid-beat: the partial acc is discarded; no output is generated.

Decomposition:
- sgbus_pkg holds:
  - idx_width() (existing);
  - lane-count typedef lane_cnt_t;
  - a constant-check function lanes_of(slv,mst) shared with stream_downsizer.
- No sub-module. Accumulator, counter and output register live in one block of about 200 lines.
- An elaboration-time check fatals if SlvStreamWidth % MstStreamWidth != 0.

Test Plan:
- Full beat: send words 0xA0..0xA3 back-to-back with m tready=1 → one beat 0xA0_A1_A2_A3 (MSB first, 64 b each), m_lane_cnt=4, tvalid in the cycle after 0xA3 is accepted.
- Backpressure: hold m tready=0 for 10 cycles after the first beat and send 8 words → s tready drops when cnt=3 with obuf full. No data loss; the second beat follows once tready=1.
- Flush partial: send 0xB0,0xB1, then pulse flush_i → beat 0xB0_B1_0_0 with m_lane_cnt=2. A flush with cnt=0 produces no beat.
- Flush + accept same cycle at cnt=3 → a single full beat and no extra beat. Flush while obuf is blocked → flush_pend=1 and s tready=0 until the partial beat is emitted.
- HF gating (UseHfBackpressure=1): m_axis_hf_resp.tready=0 → s tready=0 irrespective of obuf. Round-trip through stream_downsizer returns identical 64-bit word order.
- Async reset asserted mid-beat at cnt=2 → all outputs 0 immediately without a clock edge. The next 4 words form a clean beat.

Source files
------------

// File: rtl/sgbus_pkg.sv
// Shared scatter/gather stream bus definitions: index helpers, lane-count
// type and the default narrow/wide stream structs used by the width converters.
package sgbus_pkg;

    localparam int unsigned DefMstWidth = 64;
    localparam int unsigned DefSlvWidth = 256;

    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
    endfunction

    // Lanes per wide beat; shared with stream_downsizer so both sides agree.
    function automatic int unsigned lanes_of(input int unsigned slv, input int unsigned mst);
        return (mst == 32'd0) ? 32'd0 : slv / mst;
    endfunction

    localparam int unsigned DefLaneNum  = lanes_of(DefSlvWidth, DefMstWidth);
    localparam int unsigned DefSelWidth = idx_width(DefLaneNum);

    typedef logic [DefSelWidth:0]   lane_cnt_t;
    typedef logic [DefMstWidth-1:0] narrow_data_t;
    typedef logic [DefSlvWidth-1:0] wide_data_t;

    typedef struct packed {
        narrow_data_t data;
    } narrow_payload_t;

    typedef struct packed {
        logic            tvalid;
        narrow_payload_t t;
    } narrow_req_t;

    typedef struct packed {
        wide_data_t data;
    } wide_payload_t;

    typedef struct packed {
        logic          tvalid;
        wide_payload_t t;
    } wide_req_t;

    typedef struct packed {
        logic tready;
    } stream_resp_t;

endpackage

// File: rtl/stream_upsizer.sv
// Packs narrow stream words into full-width beats, first word in the MSB slice,
// with explicit flush of partial beats and optional half-full intake throttling.
module stream_upsizer
    import sgbus_pkg::*;
#(
    parameter int unsigned SlvStreamWidth    = DefSlvWidth,
    parameter int unsigned MstStreamWidth    = DefMstWidth,
    parameter bit          UseHfBackpressure = 1'b1,
    parameter type         s_axis_req_t      = narrow_req_t,
    parameter type         s_axis_resp_t     = stream_resp_t,
    parameter type         m_axis_req_t      = wide_req_t,
    parameter type         m_axis_resp_t     = stream_resp_t,
    parameter type         s_axis_data_t     = narrow_data_t,
    localparam int unsigned LaneNum          = lanes_of(SlvStreamWidth, MstStreamWidth),
    localparam int unsigned SelWidth         = idx_width(LaneNum)
) (
    input  logic          clk,
    input  logic          reset,
    input  s_axis_req_t   s_axis_req,
    output s_axis_resp_t  s_axis_resp,
    output m_axis_req_t   m_axis_req,
    input  m_axis_resp_t  m_axis_resp,
    input  m_axis_resp_t  m_axis_hf_resp,
    input  logic          flush_i,
    output logic [SelWidth:0] m_lane_cnt
);

    localparam int unsigned LastLane = LaneNum - 32'd1;

    if (SlvStreamWidth % MstStreamWidth != 0) begin : g_width_check
        $fatal(1, "stream_upsizer: SlvStreamWidth must be a multiple of MstStreamWidth");
    end

    logic [SelWidth-1:0]       cnt_q, cnt_d;
    logic [SlvStreamWidth-1:0] acc_q, acc_d;
    logic [SlvStreamWidth-1:0] obuf_q, obuf_d;
    logic                      ovalid_q, ovalid_d;
    logic [SelWidth:0]         olanes_q, olanes_d;
    logic                      flush_pend_q, flush_pend_d;

    logic [SlvStreamWidth-1:0] acc_merged;
    logic [SelWidth:0]         fill;
    s_axis_data_t              word_in;
    logic                      obuf_free;
    logic                      last_lane;
    logic                      s_ready;
    logic                      accept;
    logic                      flush_req;

    // Intake qualification and the accumulator with this cycle's word merged in.
    always_comb begin
        word_in   = s_axis_req.t.data;
        obuf_free = !ovalid_q || m_axis_resp.tready;
        last_lane = (cnt_q == SelWidth'(LastLane));
        s_ready   = !reset && !flush_pend_q && (!last_lane || obuf_free)
                    && (!UseHfBackpressure || m_axis_hf_resp.tready);
        accept    = s_axis_req.tvalid && s_ready;
        flush_req = flush_i || flush_pend_q;
        fill      = {1'b0, cnt_q} + (SelWidth+1)'(accept);

        acc_merged = acc_q;
        for (int unsigned i = 0; i < LaneNum; i++) begin
            if (accept && (32'(cnt_q) == LastLane - i)) begin
                acc_merged[i*MstStreamWidth +: MstStreamWidth] = word_in;
            end
        end
    end

    // Beat completion, flush handling and output-register drain.
    always_comb begin
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        obuf_d       = obuf_q;
        ovalid_d     = ovalid_q;
        olanes_d     = olanes_q;
        flush_pend_d = flush_pend_q;

        if (ovalid_q && m_axis_resp.tready) begin
            ovalid_d = 1'b0;
        end

        if (accept && last_lane) begin
            obuf_d       = acc_merged;
            olanes_d     = (SelWidth+1)'(LaneNum);
            ovalid_d     = 1'b1;
            cnt_d        = '0;
            acc_d        = '0;
            flush_pend_d = 1'b0;
        end else if (flush_req && (fill != '0)) begin
            if (obuf_free) begin
                obuf_d       = acc_merged;
                olanes_d     = fill;
                ovalid_d     = 1'b1;
                cnt_d        = '0;
                acc_d        = '0;
                flush_pend_d = 1'b0;
            end else begin
                acc_d        = acc_merged;
                cnt_d        = fill[SelWidth-1:0];
                flush_pend_d = 1'b1;
            end
        end else begin
            acc_d        = acc_merged;
            cnt_d        = fill[SelWidth-1:0];
            flush_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            obuf_q       <= '0;
            ovalid_q     <= 1'b0;
            olanes_q     <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            obuf_q       <= obuf_d;
            ovalid_q     <= ovalid_d;
            olanes_q     <= olanes_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_comb begin
        s_axis_resp        = '0;
        s_axis_resp.tready = s_ready;
        m_axis_req         = '0;
        m_axis_req.tvalid  = ovalid_q;
        m_axis_req.t.data  = obuf_q;
        m_lane_cnt         = olanes_q;
    end

endmodule

// File: tb/tb_stream_upsizer.sv
// Bench for stream_upsizer: directed scenarios plus randomized traffic against
// a queue-based packing model, with MSB-first word-order round-trip checks.
module tb_stream_upsizer;
    import sgbus_pkg::*;

    localparam int unsigned W  = 64;
    localparam int unsigned WW = 256;
    localparam int unsigned L  = WW / W;

    logic         clk;
    logic         reset;
    logic         flush_i;
    narrow_req_t  s_req;
    stream_resp_t s_resp;
    wide_req_t    m_req;
    stream_resp_t m_resp;
    stream_resp_t hf_resp;
    lane_cnt_t    lane_cnt;

    stream_upsizer dut (
        .clk            (clk),
        .reset          (reset),
        .s_axis_req     (s_req),
        .s_axis_resp    (s_resp),
        .m_axis_req     (m_req),
        .m_axis_resp    (m_resp),
        .m_axis_hf_resp (hf_resp),
        .flush_i        (flush_i),
        .m_lane_cnt     (lane_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: words waiting for a beat, the beat on the output, pending flush.
    logic [W-1:0]  mq[$];
    logic [W-1:0]  sent_q[$];
    bit            mo_v;
    logic [WW-1:0] mo_d;
    int            mo_l;
    bit            m_pend;

    function automatic logic [WW-1:0] pack_q();
        logic [WW-1:0] b;
        b = '0;
        foreach (mq[i]) b = b | (WW'(mq[i]) << (WW - W*(i+1)));
        return b;
    endfunction

    function automatic bit exp_ready();
        return !reset && !m_pend && hf_resp.tready
               && ((mq.size() != L-1) || !mo_v || m_resp.tready);
    endfunction

    task automatic model_clear();
        mq.delete();
        sent_q.delete();
        mo_v   = 1'b0;
        mo_d   = '0;
        mo_l   = 0;
        m_pend = 1'b0;
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input bit mr, input bit hr, input bit fl);
        s_req.tvalid   = v;
        s_req.t.data   = d;
        m_resp.tready  = mr;
        hf_resp.tready = hr;
        flush_i        = fl;
        #1;
    endtask

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic step();
        bit acc;
        bit free;
        acc  = s_req.tvalid && exp_ready();
        free = !mo_v || m_resp.tready;
        @(posedge clk);
        if (mo_v && m_resp.tready) mo_v = 1'b0;
        if (acc) begin
            mq.push_back(s_req.t.data);
            sent_q.push_back(s_req.t.data);
        end
        if (mq.size() == L) begin
            mo_d = pack_q(); mo_l = L; mo_v = 1'b1; mq.delete(); m_pend = 1'b0;
        end else if ((flush_i || m_pend) && mq.size() != 0) begin
            if (free) begin
                mo_d = pack_q(); mo_l = mq.size(); mo_v = 1'b1; mq.delete(); m_pend = 1'b0;
            end else begin
                m_pend = 1'b1;
            end
        end else begin
            m_pend = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, '0, 1, 1, 0);
        @(posedge clk); #1;
        n_checks++;
        if (m_req.tvalid !== 1'b0 || m_req.t.data !== '0 || lane_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: tvalid=%b lanes=%0d data=%h, want 0/0/0", m_req.tvalid, lane_cnt, m_req.t.data);
        end
        n_checks++;
        if (s_resp.tready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tready: got %b want 0", s_resp.tready);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (s_resp.tready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_tready: got %b want 1", s_resp.tready);
        end
    endtask

    task automatic test_full_beat();
        logic [WW-1:0] exp_beat;
        exp_beat = {64'hA0, 64'hA1, 64'hA2, 64'hA3};
        for (int k = 0; k < 4; k++) begin
            drive(1, 64'hA0 + 64'(k), 1, 1, 0);
            n_checks++;
            if (s_resp.tready !== 1'b1) begin
                n_fail++;
                $display("FAIL full_tready[%0d]: got %b want 1", k, s_resp.tready);
            end
            step();
            if (k < 3) begin
                n_checks++;
                if (m_req.tvalid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_early_valid[%0d]: got %b want 0", k, m_req.tvalid);
                end
            end
        end
        n_checks++;
        if (m_req.tvalid !== 1'b1 || m_req.t.data !== exp_beat || lane_cnt !== 3'd4) begin
            n_fail++;
            $display("FAIL full_beat: tvalid=%b lanes=%0d data=%h, want 1/4/%h", m_req.tvalid, lane_cnt, m_req.t.data, exp_beat);
        end
        drive(0, '0, 1, 1, 0);
        step();
        n_checks++;
        if (m_req.tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drain: tvalid=%b want 0", m_req.tvalid);
        end
    endtask

    task automatic test_backpressure();
        logic [WW-1:0] exp_b[2];
        int sent;
        int beats;
        bit stalled;
        exp_b[0] = {64'hC0, 64'hC1, 64'hC2, 64'hC3};
        exp_b[1] = {64'hC4, 64'hC5, 64'hC6, 64'hC7};
        sent = 0; beats = 0; stalled = 1'b0;
        for (int c = 0; c < 30; c++) begin
            bit mr;
            mr = (c >= 10);
            drive(sent < 8, 64'hC0 + 64'(sent), mr, 1, 0);
            n_checks++;
            if (s_resp.tready !== exp_ready()) begin
                n_fail++;
                $display("FAIL bp_tready[%0d]: got %b want %b", c, s_resp.tready, exp_ready());
            end
            if (sent < 8 && s_resp.tready === 1'b0) stalled = 1'b1;
            if (m_req.tvalid === 1'b1 && mr) begin
                n_checks++;
                if (beats > 1 || m_req.t.data !== exp_b[beats]) begin
                    n_fail++;
                    $display("FAIL bp_beat[%0d]: got %h want %h", beats, m_req.t.data, exp_b[beats % 2]);
                end
                beats++;
            end
            if (s_req.tvalid && exp_ready()) sent++;
            step();
            n_checks++;
            if (m_req.tvalid !== mo_v || (mo_v && (m_req.t.data !== mo_d || lane_cnt !== lane_cnt_t'(mo_l)))) begin
                n_fail++;
                $display("FAIL bp_out[%0d]: tvalid=%b lanes=%0d data=%h, want %b/%0d/%h", c, m_req.tvalid, lane_cnt, m_req.t.data, mo_v, mo_l, mo_d);
            end
        end
        n_checks++;
        if (beats != 2 || stalled !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_summary: beats=%0d stalled=%b, want 2/1", beats, stalled);
        end
    endtask

    task automatic test_flush();
        drive(1, 64'hB0, 1, 1, 0); step();
        drive(1, 64'hB1, 1, 1, 0); step();
        drive(0, '0, 1, 1, 1);
        n_checks++;
        if (s_resp.tready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_tready: got %b want 1", s_resp.tready);
        end
        step();
        n_checks++;
        if (m_req.tvalid !== 1'b1 || m_req.t.data !== {64'hB0, 64'hB1, 128'h0} || lane_cnt !== 3'd2) begin
            n_fail++;
            $display("FAIL flush_partial: tvalid=%b lanes=%0d data=%h", m_req.tvalid, lane_cnt, m_req.t.data);
        end
        drive(0, '0, 1, 1, 1); step();
        n_checks++;
        if (m_req.tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_empty: tvalid=%b want 0", m_req.tvalid);
        end
        drive(0, '0, 1, 1, 0); step();
        n_checks++;
        if (m_req.tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_empty2: tvalid=%b want 0", m_req.tvalid);
        end
    endtask

    task automatic test_flush_accept();
        for (int k = 0; k < 4; k++) begin
            drive(1, 64'hD0 + 64'(k), 1, 1, k == 3);
            step();
        end
        n_checks++;
        if (m_req.tvalid !== 1'b1 || m_req.t.data !== {64'hD0, 64'hD1, 64'hD2, 64'hD3} || lane_cnt !== 3'd4) begin
            n_fail++;
            $display("FAIL flush_acc_full: tvalid=%b lanes=%0d data=%h", m_req.tvalid, lane_cnt, m_req.t.data);
        end
        for (int k = 0; k < 2; k++) begin
            drive(0, '0, 1, 1, 0); step();
            n_checks++;
            if (m_req.tvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_acc_extra[%0d]: tvalid=%b want 0", k, m_req.tvalid);
            end
        end
        // Full beat held, one more word, then flush while the output is blocked.
        for (int k = 0; k < 5; k++) begin
            drive(1, 64'hE0 + 64'(k), 0, 1, 0); step();
        end
        drive(0, '0, 0, 1, 1); step();
        for (int k = 0; k < 3; k++) begin
            drive(1, 64'hE5, 0, 1, 0);
            n_checks++;
            if (s_resp.tready !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_pend_tready[%0d]: got %b want 0", k, s_resp.tready);
            end
            step();
            n_checks++;
            if (m_req.tvalid !== 1'b1 || m_req.t.data !== {64'hE0, 64'hE1, 64'hE2, 64'hE3}) begin
                n_fail++;
                $display("FAIL flush_pend_hold[%0d]: tvalid=%b data=%h", k, m_req.tvalid, m_req.t.data);
            end
        end
        drive(0, '0, 1, 1, 0);
        n_checks++;
        if (s_resp.tready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_pend_drain_tready: got %b want 0", s_resp.tready);
        end
        step();
        n_checks++;
        if (m_req.tvalid !== 1'b1 || m_req.t.data !== {64'hE4, 192'h0} || lane_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL flush_pend_emit: tvalid=%b lanes=%0d data=%h", m_req.tvalid, lane_cnt, m_req.t.data);
        end
        drive(0, '0, 1, 1, 0);
        n_checks++;
        if (s_resp.tready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pend_clear: got %b want 1", s_resp.tready);
        end
        step();
        n_checks++;
        if (m_req.tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_pend_single: tvalid=%b want 0", m_req.tvalid);
        end
    endtask

    task automatic test_hf();
        for (int k = 0; k < 3; k++) begin
            drive(1, 64'hF0, 1, 0, 0);
            n_checks++;
            if (s_resp.tready !== 1'b0) begin
                n_fail++;
                $display("FAIL hf_tready[%0d]: got %b want 0", k, s_resp.tready);
            end
            step();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1, 64'hF0 + 64'(k), 1, 1, 0); step();
        end
        n_checks++;
        if (m_req.tvalid !== 1'b1 || m_req.t.data !== {64'hF0, 64'hF1, 64'hF2, 64'hF3} || lane_cnt !== 3'd4) begin
            n_fail++;
            $display("FAIL hf_beat: tvalid=%b lanes=%0d data=%h", m_req.tvalid, lane_cnt, m_req.t.data);
        end
        drive(0, '0, 1, 1, 0); step();
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1, 64'h60 + 64'(k), 0, 1, 0); step();
        end
        drive(0, '0, 0, 1, 0);
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (m_req.tvalid !== 1'b0 || m_req.t.data !== '0 || lane_cnt !== '0 || s_resp.tready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: tvalid=%b lanes=%0d tready=%b data=%h, want all 0", m_req.tvalid, lane_cnt, s_resp.tready, m_req.t.data);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        for (int k = 0; k < 4; k++) begin
            drive(1, 64'h70 + 64'(k), 1, 1, 0); step();
        end
        n_checks++;
        if (m_req.tvalid !== 1'b1 || m_req.t.data !== {64'h70, 64'h71, 64'h72, 64'h73} || lane_cnt !== 3'd4) begin
            n_fail++;
            $display("FAIL post_reset_beat: tvalid=%b lanes=%0d data=%h", m_req.tvalid, lane_cnt, m_req.t.data);
        end
        drive(0, '0, 1, 1, 0); step();
    endtask

    task automatic test_random();
        sent_q.delete();
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0);
            n_checks++;
            if (s_resp.tready !== exp_ready()) begin
                n_fail++;
                $display("FAIL rnd_tready[%0d]: got %b want %b", c, s_resp.tready, exp_ready());
            end
            if (mo_v && m_req.tvalid === 1'b1 && m_resp.tready) begin
                for (int i = 0; i < mo_l; i++) begin
                    logic [W-1:0] got;
                    logic [W-1:0] exp_w;
                    got = W'(m_req.t.data >> (WW - W*(i+1)));
                    exp_w = (sent_q.size() != 0) ? sent_q.pop_front() : 'x;
                    n_checks++;
                    if (got !== exp_w) begin
                        n_fail++;
                        $display("FAIL rnd_order[%0d.%0d]: got %h want %h", c, i, got, exp_w);
                    end
                end
            end
            step();
            n_checks++;
            if (m_req.tvalid !== mo_v || (mo_v && (m_req.t.data !== mo_d || lane_cnt !== lane_cnt_t'(mo_l)))) begin
                n_fail++;
                $display("FAIL rnd_out[%0d]: tvalid=%b lanes=%0d data=%h, want %b/%0d/%h", c, m_req.tvalid, lane_cnt, m_req.t.data, mo_v, mo_l, mo_d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_beat();
        test_backpressure();
        test_flush();
        test_flush_accept();
        test_hf();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
